// File: rtl/monocular_pkg.sv
// monocular_pkg: shared opcodes, handshake bytes and command FSM states
package monocular_pkg;
  localparam logic [7:0] OP_NOP      = 8'h00;
  localparam logic [7:0] OP_PINS     = 8'h01;
  localparam logic [7:0] OP_STATUS   = 8'h02;
  localparam logic [7:0] OP_START    = 8'h03;
  localparam logic [7:0] OP_READ_BUF = 8'h04;
  localparam logic [7:0] ACK         = 8'hA5;
  localparam logic [7:0] NAK         = 8'hEE;
  typedef enum logic [1:0] {IDLE, GET_LEN, FETCH, STREAM} state_t;
endpackage

// File: rtl/idle_timer.sv
// idle_timer: counts cycles since last clear, emits a 1-cycle expired pulse after TIMEOUT_CYCLES
module idle_timer #(
  parameter int TIMEOUT_CYCLES = 16000
) (
  input  logic CLK,
  input  logic reset,
  input  logic clear,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge CLK) begin
    if (reset || clear) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else begin
      cnt     <= cnt + 1'b1;
      expired <= cnt == W'(TIMEOUT_CYCLES - 1);
    end
  end
endmodule

// File: rtl/spi_cmd_controller.sv
// spi_cmd_controller: SPI opcode decoder, capture starter and sample-buffer streamer
module spi_cmd_controller
  import monocular_pkg::*;
#(
  parameter int         ADDR_W         = 8,
  parameter int         TIMEOUT_CYCLES = 16000,
  parameter logic [3:0] VERSION        = 4'h1
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic [7:0]        tx_byte,
  input  logic [7:0]        pin_values,
  output logic              cap_start,
  input  logic              cap_busy,
  input  logic              cap_done,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] buf_rd_addr,
  input  logic [7:0]        buf_rd_data
);
  state_t          state;
  logic            err;
  logic [ADDR_W:0] remaining;
  logic            expired;
  idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .CLK     (CLK),
    .reset   (reset),
    .clear   (rx_valid || state == IDLE),
    .expired (expired)
  );
  // buf_rd_addr doubles as the stream address; buf_rd_en marks the first FETCH cycle
  always_ff @(posedge CLK) begin
    if (reset) begin
      state       <= IDLE;
      tx_byte     <= 8'h00;
      cap_start   <= 1'b0;
      buf_rd_en   <= 1'b0;
      buf_rd_addr <= '0;
      err         <= 1'b0;
      remaining   <= '0;
    end else begin
      cap_start <= 1'b0;
      if (state != IDLE && expired) begin
        state     <= IDLE;
        tx_byte   <= 8'h00;
        err       <= 1'b1;
        buf_rd_en <= 1'b0;
      end else begin
        case (state)
          IDLE: if (rx_valid) begin
            case (rx_byte)
              OP_NOP:    tx_byte <= 8'h00;
              OP_PINS:   tx_byte <= pin_values;
              OP_STATUS: begin
                tx_byte <= {cap_busy, cap_done, err, 1'b0, VERSION};
                err     <= 1'b0;
              end
              OP_START: begin
                tx_byte   <= cap_busy ? NAK : ACK;
                cap_start <= !cap_busy;
              end
              OP_READ_BUF: begin
                tx_byte <= ACK;
                state   <= GET_LEN;
              end
              default: begin
                tx_byte <= NAK;
                err     <= 1'b1;
              end
            endcase
          end
          GET_LEN: if (rx_valid) begin
            remaining   <= rx_byte == 8'h00 ? (ADDR_W+1)'(1 << ADDR_W) : (ADDR_W+1)'(rx_byte);
            buf_rd_addr <= '0;
            buf_rd_en   <= 1'b1;
            state       <= FETCH;
          end
          FETCH: begin
            if (rx_valid) err <= 1'b1;
            if (buf_rd_en) buf_rd_en <= 1'b0;
            else begin
              tx_byte <= buf_rd_data;
              state   <= STREAM;
            end
          end
          STREAM: if (rx_valid) begin
            buf_rd_addr <= buf_rd_addr + 1'b1;
            remaining   <= remaining - 1'b1;
            if (remaining == (ADDR_W+1)'(1)) begin
              tx_byte <= 8'h00;
              state   <= IDLE;
            end else begin
              buf_rd_en <= 1'b1;
              state     <= FETCH;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_cmd_controller.sv
// tb_spi_cmd_controller: table-driven opcode checks plus hand-written stream, timeout and reset sequences
module tb_spi_cmd_controller;
  localparam int TO  = 16000;
  localparam int GAP = 18;
  logic       CLK = 1'b0;
  logic       reset;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] tx_byte;
  logic [7:0] pin_values;
  logic       cap_start;
  logic       cap_busy;
  logic       cap_done;
  logic       buf_rd_en;
  logic [7:0] buf_rd_addr;
  logic [7:0] buf_rd_data;
  logic [7:0] mem [256];
  int         tests = 0;
  int         failed = 0;
  int         pulses = 0;
  always #5 CLK = ~CLK;
  spi_cmd_controller #(.ADDR_W(8), .TIMEOUT_CYCLES(TO), .VERSION(4'h1)) dut (
    .CLK         (CLK),
    .reset       (reset),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .tx_byte     (tx_byte),
    .pin_values  (pin_values),
    .cap_start   (cap_start),
    .cap_busy    (cap_busy),
    .cap_done    (cap_done),
    .buf_rd_en   (buf_rd_en),
    .buf_rd_addr (buf_rd_addr),
    .buf_rd_data (buf_rd_data)
  );
  always @(posedge CLK) if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];
  always @(posedge CLK) if (cap_start) pulses <= pulses + 1;
  typedef struct {
    logic [7:0] op;
    logic [7:0] pins;
    logic       busy;
    logic       done;
    logic [7:0] exp_tx;
    int         exp_pulses;
  } vec_t;
  vec_t vecs [12];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0;
    repeat (GAP) @(negedge CLK);
  endtask
  initial begin
    int p0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 3);
    vecs[0]  = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 0};
    vecs[1]  = '{8'h01, 8'h5A, 1'b0, 1'b0, 8'h5A, 0};
    vecs[2]  = '{8'h00, 8'h5A, 1'b0, 1'b0, 8'h00, 0};
    vecs[3]  = '{8'h01, 8'hC3, 1'b0, 1'b0, 8'hC3, 0};
    vecs[4]  = '{8'h02, 8'h00, 1'b0, 1'b0, 8'h01, 0};
    vecs[5]  = '{8'h03, 8'h00, 1'b0, 1'b0, 8'hA5, 1};
    vecs[6]  = '{8'h03, 8'h00, 1'b1, 1'b0, 8'hEE, 0};
    vecs[7]  = '{8'h7F, 8'h00, 1'b0, 1'b0, 8'hEE, 0};
    vecs[8]  = '{8'h02, 8'h00, 1'b1, 1'b1, 8'hE1, 0};
    vecs[9]  = '{8'h02, 8'h00, 1'b0, 1'b1, 8'h41, 0};
    vecs[10] = '{8'hFF, 8'h00, 1'b0, 1'b0, 8'hEE, 0};
    vecs[11] = '{8'h02, 8'h00, 1'b0, 1'b0, 8'h21, 0};
    reset = 1'b1; rx_byte = 8'h00; rx_valid = 1'b0;
    pin_values = 8'h00; cap_busy = 1'b0; cap_done = 1'b0;
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    check("reset_tx", tx_byte, 8'h00);
    check("reset_cap_start", cap_start, 0);
    check("reset_rd_en", buf_rd_en, 0);
    check("reset_rd_addr", buf_rd_addr, 8'h00);
    @(negedge CLK);
    for (int i = 0; i < 12; i++) begin
      pin_values = vecs[i].pins;
      cap_busy   = vecs[i].busy;
      cap_done   = vecs[i].done;
      p0 = pulses;
      send(vecs[i].op);
      check($sformatf("vec%0d_tx", i), tx_byte, vecs[i].exp_tx);
      check($sformatf("vec%0d_pulses", i), pulses - p0, vecs[i].exp_pulses);
    end
    cap_busy = 1'b0; cap_done = 1'b0;
    p0 = pulses;
    rx_byte = 8'h03; rx_valid = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0;
    cap_busy = 1'b1;
    repeat (GAP) @(negedge CLK);
    check("start_busy_rise_pulses", pulses - p0, 1);
    check("start_busy_rise_tx", tx_byte, 8'hA5);
    cap_busy = 1'b0;
    send(8'h04);
    check("rb3_ack", tx_byte, 8'hA5);
    send(8'h03);
    check("rb3_b0", tx_byte, 8'h00);
    send(8'h00);
    check("rb3_b1", tx_byte, 8'h03);
    send(8'h00);
    check("rb3_b2", tx_byte, 8'h06);
    send(8'h00);
    check("rb3_end_tx", tx_byte, 8'h00);
    check("rb3_end_addr", buf_rd_addr, 8'h03);
    pin_values = 8'h96;
    send(8'h01);
    check("rb3_idle_pins", tx_byte, 8'h96);
    send(8'h04);
    send(8'h00);
    check("rb256_b0", tx_byte, mem[0]);
    for (int k = 1; k < 256; k++) begin
      send(8'h00);
      check($sformatf("rb256_b%0d", k), tx_byte, mem[k]);
    end
    send(8'h00);
    check("rb256_end_tx", tx_byte, 8'h00);
    check("rb256_end_addr", buf_rd_addr, 8'h00);
    pin_values = 8'h3C;
    send(8'h01);
    check("rb256_idle_pins", tx_byte, 8'h3C);
    send(8'h04);
    send(8'h02);
    rx_byte = 8'h00; rx_valid = 1'b1;
    @(negedge CLK);
    rx_byte = 8'h55;
    @(negedge CLK);
    rx_valid = 1'b0;
    repeat (GAP) @(negedge CLK);
    check("fetch_viol_tx", tx_byte, 8'h03);
    send(8'h00);
    check("fetch_viol_end", tx_byte, 8'h00);
    send(8'h02);
    check("fetch_viol_err", tx_byte, 8'h21);
    send(8'h02);
    check("fetch_viol_err_clr", tx_byte, 8'h01);
    send(8'h04);
    send(8'h05);
    send(8'h00);
    check("to_pre_tx", tx_byte, 8'h03);
    repeat (TO - 40) @(negedge CLK);
    check("to_not_early", tx_byte, 8'h03);
    repeat (40) @(negedge CLK);
    check("to_abort_tx", tx_byte, 8'h00);
    send(8'h02);
    check("to_status_err", tx_byte, 8'h21);
    send(8'h02);
    check("to_status_clr", tx_byte, 8'h01);
    send(8'h04);
    send(8'h10);
    send(8'h00);
    check("rst_pre_tx", tx_byte, 8'h03);
    rx_byte = 8'h00; rx_valid = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0;
    check("rst_pre_rd_en", buf_rd_en, 1);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    check("rst_tx", tx_byte, 8'h00);
    check("rst_rd_en", buf_rd_en, 0);
    check("rst_rd_addr", buf_rd_addr, 8'h00);
    repeat (GAP) @(negedge CLK);
    pin_values = 8'hB7;
    send(8'h01);
    check("rst_idle_pins", tx_byte, 8'hB7);
    send(8'h02);
    check("rst_status", tx_byte, 8'h01);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
